// File: rtl/fft_rd_addr_gen.sv
// Read-side sequencer for a constant-geometry radix-2 FFT: issues N/2 butterfly
// reads per level and waits for the write-back path between levels.
module fft_rd_addr_gen #(
    parameter int LOG2N      = 10,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  hold,
    input  logic                  wb_level_done,
    output logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  i_rd_valid,
    output logic                  first_level,
    output logic [LOG2N-2:0]      tw_addr,
    output logic                  rd_bank,
    output logic [4:0]            level,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = LOG2N - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_WB = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  valid_d, first_d, bank_d, busy_d, done_d;
    logic [CW-1:0]         tw_d;
    logic [4:0]            level_d;
    logic [CW-1:0]         tw_mask;

    // Clearing the low 'level' bits of the butterfly index gives the twiddle index.
    assign tw_mask = {CW{1'b1}} << level;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = 1'b0;
        addr_d  = i_rd_addr;
        valid_d = 1'b0;
        first_d = first_level;
        tw_d    = tw_addr;
        bank_d  = rd_bank;
        level_d = level;
        busy_d  = busy;
        done_d  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            first_d = 1'b0;
            bank_d  = 1'b0;
            level_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A start seen while the done pulse is still showing is dropped.
                    if (start && !done) begin
                        state_d = RUN;
                        addr_d  = '0;
                        tw_d    = '0;
                        valid_d = 1'b1;
                        cnt_d   = CW'(1);
                        first_d = 1'b1;
                        bank_d  = 1'b0;
                        level_d = '0;
                        busy_d  = 1'b1;
                    end
                end
                RUN: begin
                    // last_q marks the cycle in which the final read of the level is visible.
                    if (last_q) begin
                        state_d = WAIT_WB;
                        cnt_d   = '0;
                    end else if (!hold) begin
                        addr_d  = ADDR_WIDTH'(cnt_q);
                        tw_d    = cnt_q & tw_mask;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CW'(1);
                        last_d  = (cnt_q == {CW{1'b1}});
                    end
                end
                WAIT_WB: begin
                    if (wb_level_done) begin
                        if (level == 5'(LOG2N - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            level_d = '0;
                            bank_d  = 1'b0;
                            first_d = 1'b0;
                        end else begin
                            state_d = RUN;
                            level_d = level + 5'd1;
                            bank_d  = ~rd_bank;
                            first_d = 1'b0;
                            addr_d  = '0;
                            tw_d    = '0;
                            valid_d = 1'b1;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            i_rd_addr   <= '0;
            i_rd_valid  <= 1'b0;
            first_level <= 1'b0;
            tw_addr     <= '0;
            rd_bank     <= 1'b0;
            level       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            i_rd_addr   <= addr_d;
            i_rd_valid  <= valid_d;
            first_level <= first_d;
            tw_addr     <= tw_d;
            rd_bank     <= bank_d;
            level       <= level_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_fft_rd_addr_gen.sv
// Bench for fft_rd_addr_gen at LOG2N=4: vector table, directed corner sequences,
// and randomized hold/write-back traffic checked against an expected read queue.
module tb_fft_rd_addr_gen;

    localparam int LOG2N = 4;
    localparam int AW    = 5;
    localparam int CW    = LOG2N - 1;
    localparam int HALF  = 1 << (LOG2N - 1);
    localparam int W     = 5 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, hold, wb_level_done;
    logic [AW-1:0] i_rd_addr;
    logic          i_rd_valid, first_level, rd_bank, busy, done;
    logic [CW-1:0] tw_addr;
    logic [4:0]    level;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fft_rd_addr_gen #(.LOG2N(LOG2N), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .wb_level_done(wb_level_done), .i_rd_addr(i_rd_addr), .i_rd_valid(i_rd_valid),
        .first_level(first_level), .tw_addr(tw_addr), .rd_bank(rd_bank),
        .level(level), .busy(busy), .done(done)
    );

    typedef struct {
        logic          start, abort, hold, wb;
        logic          e_valid, e_busy, e_first, e_done;
        logic [4:0]    e_level;
        logic          chk_addr;
        logic [AW-1:0] e_addr;
        logic [CW-1:0] e_tw;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(int s, int a, int h, int w, int v, int b, int f, int d,
                                int lv, int ca, int ad, int tw);
        vec_t r;
        r.start = s[0]; r.abort = a[0]; r.hold = h[0]; r.wb = w[0];
        r.e_valid = v[0]; r.e_busy = b[0]; r.e_first = f[0]; r.e_done = d[0];
        r.e_level = 5'(lv); r.chk_addr = ca[0]; r.e_addr = AW'(ad); r.e_tw = CW'(tw);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Full transform; expected reads come from the level/index arithmetic alone.
    task automatic run_xfer(input bit rnd, input bit dir_hold, input bit start_hold);
        logic [W-1:0] e;
        bit exp_valid, exp_done, in_wait, last_now, done_seen;
        int wait_cycles, hold_left, cur_lvl;
        exp_valid = 1'b1; exp_done = 1'b0; in_wait = 1'b0; done_seen = 1'b0;
        wait_cycles = 0; hold_left = 0; cur_lvl = 0;
        exp_q.delete();
        for (int l = 0; l < LOG2N; l++)
            for (int i = 0; i < HALF; i++)
                exp_q.push_back({5'(l), CW'(i), CW'((i >> l) << l)});
        start = 1'b1; hold = 1'b0; wb_level_done = 1'b0; abort = 1'b0;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            chk("rd_valid", i_rd_valid, exp_valid);
            chk("done", done, exp_done);
            last_now = 1'b0;
            if (exp_done) begin
                chk("busy_at_done", busy, 0);
                chk("level_at_done", level, 0);
                chk("first_at_done", first_level, 0);
                done_seen = 1'b1;
            end else begin
                chk("busy", busy, 1);
                if (i_rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL extra_read: got addr %0h expected no read", i_rd_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_addr", i_rd_addr, AW'(e[2*CW-1:CW]));
                        chk("tw_addr", tw_addr, e[CW-1:0]);
                        chk("level", level, e[W-1:2*CW]);
                        chk("rd_bank", rd_bank, e[2*CW]);
                        chk("first_level", first_level, e[W-1:2*CW] == 5'd0);
                        cur_lvl = int'(e[W-1:2*CW]);
                        last_now = (e[2*CW-1:CW] == CW'(HALF - 1));
                    end
                end
            end
            if (done_seen) begin
                start = start_hold; hold = 1'b0; wb_level_done = 1'b0;
            end else begin
                if (rnd) begin
                    hold = ($urandom_range(0, 2) == 0);
                    wb_level_done = ($urandom_range(0, 3) == 0);
                end else begin
                    if (dir_hold && i_rd_valid && cur_lvl == 1 && (i_rd_addr == 2 || i_rd_addr == 4))
                        hold_left = 2;
                    hold = (hold_left > 0);
                    if (hold_left > 0) hold_left--;
                    wb_level_done = in_wait && (wait_cycles == 2);
                end
                if (in_wait) begin
                    wait_cycles++;
                    if (wb_level_done) begin
                        in_wait = 1'b0;
                        if (cur_lvl == LOG2N - 1) begin
                            exp_done = 1'b1; exp_valid = 1'b0; start = start_hold;
                        end else begin
                            exp_valid = 1'b1;
                        end
                    end else begin
                        exp_valid = 1'b0;
                    end
                end else if (last_now) begin
                    in_wait = 1'b1; wait_cycles = 0; exp_valid = 1'b0;
                end else begin
                    exp_valid = !hold;
                end
            end
            tick();
        end
        if (!done_seen) begin
            n_cmp++; n_err++;
            $display("FAIL xfer_timeout: got no done expected done within budget");
        end
        chk("reads_left", exp_q.size(), 0);
        chk("post_done_done", done, 0);
        chk("post_done_busy", busy, 0);
        chk("post_done_valid", i_rd_valid, 0);
        start = 1'b0; hold = 1'b0; wb_level_done = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; wb_level_done = 1'b0;
        repeat (3) tick();
        chk("rst_addr", i_rd_addr, 0);   chk("rst_valid", i_rd_valid, 0);
        chk("rst_first", first_level, 0); chk("rst_tw", tw_addr, 0);
        chk("rst_bank", rd_bank, 0);      chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        rst_n = 1'b1;

        tbl[0]  = mk(0,0,0,1, 0,0,0,0, 0, 1, 0, 0);
        tbl[1]  = mk(1,1,0,0, 0,0,0,0, 0, 1, 0, 0);
        tbl[2]  = mk(1,0,0,0, 1,1,1,0, 0, 1, 0, 0);
        tbl[3]  = mk(0,0,1,0, 0,1,1,0, 0, 1, 0, 0);
        tbl[4]  = mk(0,0,0,0, 1,1,1,0, 0, 1, 1, 1);
        tbl[5]  = mk(0,0,0,1, 1,1,1,0, 0, 1, 2, 2);
        tbl[6]  = mk(0,0,0,0, 1,1,1,0, 0, 1, 3, 3);
        tbl[7]  = mk(0,1,0,0, 0,0,0,0, 0, 0, 0, 0);
        tbl[8]  = mk(1,0,0,0, 1,1,1,0, 0, 1, 0, 0);
        tbl[9]  = mk(1,0,0,0, 1,1,1,0, 0, 1, 1, 1);
        tbl[10] = mk(0,1,0,0, 0,0,0,0, 0, 0, 0, 0);
        for (int k = 0; k < 11; k++) begin
            start = tbl[k].start; abort = tbl[k].abort;
            hold = tbl[k].hold; wb_level_done = tbl[k].wb;
            tick();
            chk("tbl_valid", i_rd_valid, tbl[k].e_valid);
            chk("tbl_busy", busy, tbl[k].e_busy);
            chk("tbl_first", first_level, tbl[k].e_first);
            chk("tbl_done", done, tbl[k].e_done);
            chk("tbl_level", level, tbl[k].e_level);
            if (tbl[k].chk_addr) begin
                chk("tbl_addr", i_rd_addr, tbl[k].e_addr);
                chk("tbl_tw", tw_addr, tbl[k].e_tw);
            end
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0; wb_level_done = 1'b0;
        tick();

        // Directed transform with level-1 holds and start held across done.
        run_xfer(1'b0, 1'b1, 1'b1);

        // Abort at level 2, read 4.
        start = 1'b1; tick(); start = 1'b0;
        wb_level_done = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 500 && !found; cyc++) begin
            if (i_rd_valid && level == 5'd2 && i_rd_addr == AW'(4)) found = 1'b1;
            else tick();
        end
        chk("abort_target_reached", found, 1);
        abort = 1'b1; wb_level_done = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", i_rd_valid, 0); chk("abort_busy", busy, 0);
        chk("abort_level", level, 0);      chk("abort_first", first_level, 0);
        chk("abort_done", done, 0);
        repeat (3) begin
            tick();
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
        end
        run_xfer(1'b0, 1'b0, 1'b0);

        // One-cycle reset mid-run.
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_addr", i_rd_addr, 0);  chk("midrst_valid", i_rd_valid, 0);
        chk("midrst_tw", tw_addr, 0);      chk("midrst_bank", rd_bank, 0);
        chk("midrst_level", level, 0);     chk("midrst_busy", busy, 0);
        chk("midrst_first", first_level, 0); chk("midrst_done", done, 0);
        repeat (3) begin
            tick();
            chk("midrst_idle_busy", busy, 0);
            chk("midrst_idle_valid", i_rd_valid, 0);
        end

        for (int r = 0; r < 3; r++) run_xfer(1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
